// File: rtl/uni_shift_pkg.sv
// Shared opcodes, FSM encoding and op classification for the sequenced universal shift register.
package uni_shift_pkg;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_LOAD = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ASR  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Only shifts and rotates make sense to repeat; HOLD/LOAD/CLR always finish in one edge.
    function automatic logic is_iterative(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
               (op == OP_ROL) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/uni_shift_reg_seq_shift_step.sv
// One combinational step of the universal shift register; the top applies it once per update edge.
module shift_step
    import uni_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             serialright_i,
    input  logic             serialleft_i,
    output logic [WIDTH-1:0] q_next_o
);

    always_comb begin
        q_next_o = q_i;
        case (op_i)
            OP_HOLD: q_next_o = q_i;
            OP_SHR:  q_next_o = {serialright_i, q_i[WIDTH-1:1]};
            OP_SHL:  q_next_o = {q_i[WIDTH-2:0], serialleft_i};
            OP_LOAD: q_next_o = in_i;
            OP_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
            OP_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            OP_ASR:  q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            OP_CLR:  q_next_o = '0;
            default: q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/uni_shift_reg_seq.sv
// WIDTH-bit universal shift register that repeats a shift/rotate AMOUNT times under a
// start/busy/done handshake; serial inputs stay live on every shift edge for streaming.
module uni_shift_reg_seq
    import uni_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] in,
    input  logic             serialright,
    input  logic             serialleft,
    output logic [WIDTH-1:0] q,
    output logic             serout_r,
    output logic             serout_l,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic [2:0]       step_op;
    logic [WIDTH-1:0] step_q;

    // In IDLE the first step uses the live opcode; in RUN the latched one, so op changes are ignored.
    assign step_op = (state_q == ST_RUN) ? op_q : op;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q_i           (q_q),
        .op_i          (step_op),
        .in_i          (in),
        .serialright_i (serialright),
        .serialleft_i  (serialleft),
        .q_next_o      (step_q)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        op_d    = op_q;
        q_d     = q_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = op;
                    if (is_iterative(op) && (amount > CNT_W'(1))) begin
                        q_d     = step_q;
                        rem_d   = amount - CNT_W'(1);
                        state_d = ST_RUN;
                    end else begin
                        if (amount != '0) q_d = step_q;
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                q_d   = step_q;
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            op_q    <= OP_HOLD;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign q        = q_q;
    assign serout_r = q_q[0];
    assign serout_l = q_q[WIDTH-1];
    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;

endmodule

// File: tb/tb_uni_shift_reg_seq.sv
// Scoreboard bench: commands push their final q; a monitor pops and compares on every done pulse.
module tb_uni_shift_reg_seq;
    import uni_shift_pkg::*;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op = OP_HOLD;
    logic [CW-1:0] amount = '0;
    logic [W-1:0]  in = '0;
    logic          serialright = 1'b0;
    logic          serialleft = 1'b0;
    logic [W-1:0]  q;
    logic          serout_r, serout_l, busy, done;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] trace[$];

    uni_shift_reg_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .op          (op),
        .amount      (amount),
        .in          (in),
        .serialright (serialright),
        .serialleft  (serialleft),
        .q           (q),
        .serout_r    (serout_r),
        .serout_l    (serout_l),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [W-1:0] e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=q_%0h expected=no_done", q);
            end else begin
                e = exp_q.pop_front();
                chk("done_q", {24'd0, q}, {24'd0, e});
            end
        end
    end

    // Issue one command, then follow it to its done pulse, recording q each cycle.
    task automatic run_cmd(input string name, input logic [2:0] o, input logic [CW-1:0] a,
                           input logic [W-1:0] d, input logic sr, input logic sl,
                           input logic [W-1:0] eq, input int eb, input bit poke);
        int nb;
        bit fin;
        @(negedge clk);
        op = o; amount = a; in = d; serialright = sr; serialleft = sl; start = 1'b1;
        exp_q.push_back(eq);
        trace.delete();
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        fin = 1'b0;
        for (int c = 0; c < 100; c++) begin
            trace.push_back(q);
            if (done) begin
                fin = 1'b1;
                break;
            end
            if (busy) nb++;
            if (poke) begin
                if (nb == 3 || nb == 6) begin
                    start = 1'b1; op = OP_LOAD; in = 8'hFF; amount = CW'(1);
                end else start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, "_finished"}, 32'(fin), 32'd1);
        chk({name, "_busy_cycles"}, nb, eb);
    endtask

    initial begin
        // Reset held with a start pending: outputs must stay zero.
        start = 1'b1; op = OP_LOAD; in = 8'hFF; amount = CW'(1);
        repeat (3) @(negedge clk);
        chk("rst_q", {24'd0, q}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        start = 1'b0;
        clr = 1'b0;

        run_cmd("load_a5", OP_LOAD, CW'(1), 8'hA5, 1'b0, 1'b0, 8'hA5, 0, 1'b0);

        run_cmd("shr3", OP_SHR, CW'(3), 8'h00, 1'b1, 1'b0, 8'hF4, 2, 1'b0);
        chk("shr3_len", trace.size(), 32'd3);
        if (trace.size() == 3) begin
            chk("shr3_step1", {24'd0, trace[0]}, 32'hD2);
            chk("shr3_step2", {24'd0, trace[1]}, 32'hE9);
            chk("shr3_step3", {24'd0, trace[2]}, 32'hF4);
        end

        // Reset while idle.
        @(negedge clk);
        clr = 1'b1;
        #1 chk("idle_clr_q", {24'd0, q}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        chk("idle_clr_busy", 32'(busy), 32'd0);
        chk("idle_clr_done", 32'(done), 32'd0);

        run_cmd("load_81", OP_LOAD, CW'(1), 8'h81, 1'b0, 1'b0, 8'h81, 0, 1'b0);
        run_cmd("rol12", OP_ROL, CW'(12), 8'h00, 1'b0, 1'b0, 8'h18, 11, 1'b1);

        run_cmd("load_90", OP_LOAD, CW'(1), 8'h90, 1'b0, 1'b0, 8'h90, 0, 1'b0);
        run_cmd("asr2", OP_ASR, CW'(2), 8'h00, 1'b0, 1'b0, 8'hE4, 1, 1'b0);
        chk("asr2_serout_l", 32'(serout_l), 32'd1);
        chk("asr2_serout_r", 32'(serout_r), 32'd0);

        run_cmd("hold0", OP_HOLD, CW'(0), 8'h00, 1'b0, 1'b0, 8'hE4, 0, 1'b0);
        run_cmd("ror8", OP_ROR, CW'(8), 8'h00, 1'b0, 1'b0, 8'hE4, 7, 1'b0);
        run_cmd("shl1", OP_SHL, CW'(1), 8'h00, 1'b0, 1'b1, 8'hC9, 0, 1'b0);

        // Abort a SHL-by-5 after two steps: no done pulse may follow.
        run_cmd("load_ff", OP_LOAD, CW'(1), 8'hFF, 1'b0, 1'b0, 8'hFF, 0, 1'b0);
        @(negedge clk);
        op = OP_SHL; amount = CW'(5); serialleft = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy_mid", 32'(busy), 32'd1);
        chk("abort_q_step1", {24'd0, q}, 32'hFE);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("abort_q", {24'd0, q}, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);

        // Back-to-back commands issued in done cycles.
        run_cmd("load_a5b", OP_LOAD, CW'(1), 8'hA5, 1'b0, 1'b0, 8'hA5, 0, 1'b0);
        op = OP_SHR; amount = CW'(2); serialright = 1'b0; start = 1'b1;
        exp_q.push_back(8'h29);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_multi_done_low", 32'(done), 32'd0);
        chk("b2b_multi_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2b_multi_done", 32'(done), 32'd1);
        op = OP_LOAD; in = 8'h3C; amount = CW'(1); start = 1'b1;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_single_done", 32'(done), 32'd1);
        chk("b2b_single_q", {24'd0, q}, 32'h3C);
        @(negedge clk);
        chk("b2b_done_drop", 32'(done), 32'd0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
